// File: rtl/seq_sub_flag_gen_pkg.sv
// Shared definitions for the sequential subtract-and-flag generator:
// FSM state encoding, default geometry and slice-index sizing.
package seq_sub_flag_gen_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

  // Slice counter width; a single-slice build still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_CHUNKS = DEF_WIDTH / DEF_CHUNK;
  localparam int IDX_W    = idx_width(N_CHUNKS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_sub_flag_gen_if.sv
// Operand/flag handshake bundle for seq_sub_flag_gen.
// The diff bus is only present when SEQ_SUB_DIFF_EN is defined.
interface seq_sub_flag_gen_if #(
  parameter int WIDTH = 64
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flags_valid;
  logic             flags_ready;
  logic             c_o;
  logic             eq;
  logic             neg;
  logic             ovf;
`ifdef SEQ_SUB_DIFF_EN
  logic [WIDTH-1:0] diff;
`endif

  modport master (
    output start_valid, a, b, flags_ready,
`ifdef SEQ_SUB_DIFF_EN
    input  diff,
`endif
    input  start_ready, flags_valid, c_o, eq, neg, ovf
  );

  modport slave (
    input  start_valid, a, b, flags_ready,
`ifdef SEQ_SUB_DIFF_EN
    output diff,
`endif
    output start_ready, flags_valid, c_o, eq, neg, ovf
  );

endinterface

// File: rtl/seq_sub_flag_gen_sub_chunk_adder.sv
// One CHUNK-bit slice of A + ~B + cin, with carry out and a zero-result flag.
module sub_chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             zero
);

  logic [CHUNK:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
  assign sum    = full_s[CHUNK-1:0];
  assign cout   = full_s[CHUNK];
  assign zero   = (full_s[CHUNK-1:0] == {CHUNK{1'b0}});

endmodule

// File: rtl/seq_sub_flag_gen.sv
// Multi-cycle A - B flag generator, one CHUNK slice per cycle, LSB first.
// Define SEQ_SUB_DIFF_EN to expose the full difference on the diff port.
module seq_sub_flag_gen
  import seq_sub_flag_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic               clk,
  input logic               rst_n,
  seq_sub_flag_gen_if.slave bus
);

  localparam int            N_S      = WIDTH / CHUNK;
  localparam int            IW_S     = idx_width(N_S);
  localparam logic [IW_S-1:0] LAST_IDX = IW_S'(N_S - 1);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             carry_r;
  logic             eq_acc_r;
  logic [IW_S-1:0]  idx_r;
  logic [CHUNK-1:0] sum_s;
  logic             cout_s;
  logic             zero_s;
  logic             accept_s;
  logic             run_s;
  logic             done_s;
  logic             top_msb_s;

  assign accept_s = (state_r == ST_IDLE) & bus.start_valid;
  assign run_s    = (state_r == ST_RUN);
  assign done_s   = (state_r == ST_DONE);

  // Operands are shifted down so the active slice always sits in bits [CHUNK-1:0].
  sub_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a    (a_r[CHUNK-1:0]),
    .b    (b_r[CHUNK-1:0]),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s),
    .zero (zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_valid) state_s = ST_RUN;
        else                 state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (idx_r == LAST_IDX) state_s = ST_DONE;
        else                   state_s = ST_RUN;
      end
      ST_DONE: begin
        if (bus.flags_ready) state_s = ST_IDLE;
        else                 state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand capture, carry ripple and slice-zero accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      carry_r  <= 1'b1;
      eq_acc_r <= 1'b1;
      idx_r    <= {IW_S{1'b0}};
    end else if (accept_s) begin
      a_r      <= bus.a;
      b_r      <= bus.b;
      a_msb_r  <= bus.a[WIDTH-1];
      b_msb_r  <= bus.b[WIDTH-1];
      carry_r  <= 1'b1;
      eq_acc_r <= 1'b1;
      idx_r    <= {IW_S{1'b0}};
    end else if (run_s) begin
      a_r      <= a_r >> CHUNK;
      b_r      <= b_r >> CHUNK;
      carry_r  <= cout_s;
      eq_acc_r <= eq_acc_r & zero_s;
      idx_r    <= idx_r + IW_S'(1);
    end
  end

`ifdef SEQ_SUB_DIFF_EN
  logic [WIDTH-1:0] diff_r;

  // Difference fills from the top; after N slices it is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= {WIDTH{1'b0}};
    end else if (run_s) begin
      diff_r <= {sum_s, diff_r[WIDTH-1:CHUNK]};
    end
  end

  assign top_msb_s = diff_r[WIDTH-1];
  assign bus.diff  = diff_r;
`else
  logic top_msb_r;
  logic unused_sum_s;

  // Only the sign of the last slice is needed for neg/ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_msb_r <= 1'b0;
    end else if (run_s) begin
      top_msb_r <= sum_s[CHUNK-1];
    end
  end

  assign top_msb_s    = top_msb_r;
  assign unused_sum_s = ^sum_s[CHUNK-2:0];
`endif

  assign bus.start_ready = (state_r == ST_IDLE);
  assign bus.flags_valid = done_s;
  assign bus.c_o         = done_s & carry_r;
  assign bus.eq          = done_s & eq_acc_r;
  assign bus.neg         = done_s & top_msb_s;
  assign bus.ovf         = done_s & (a_msb_r ^ b_msb_r) & (top_msb_s ^ a_msb_r);

endmodule
